// File: rtl/jk_register_controller.sv
// Command sequencer that drives the per-bit J/K inputs of a WIDTH-bit JK register bank.
// One command is accepted per IDLE cycle. Multi-step ops run in EXEC, then DONE pulses.
module jk_register_controller #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_async,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_len,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_NOP        = 3'b000,
        OP_CLEAR      = 3'b001,
        OP_SET        = 3'b010,
        OP_COMPLEMENT = 3'b011,
        OP_LOAD       = 3'b100,
        OP_COUNT_UP   = 3'b101,
        OP_COUNT_DOWN = 3'b110,
        OP_SHIFT_LEFT = 3'b111
    } op_e;

    state_e             state_q;
    op_e                op_q;
    logic [WIDTH-1:0]   data_q;
    logic [CNT_W-1:0]   rem_q;
    logic [WIDTH-1:0]   q_q;
    logic [WIDTH-1:0]   q_d;
    logic               done_q;
    logic               busy_q;
    logic               ready_q;
    logic [WIDTH-1:0]   jDrive;
    logic [WIDTH-1:0]   kDrive;
    logic [WIDTH-1:0]   upToggle;
    logic [WIDTH-1:0]   downToggle;
    logic [WIDTH-1:0]   shifted;
    op_e                cmdOp;
    logic               isStepOp;

    assign cmdOp    = op_e'(cmd_op);
    assign isStepOp = (cmdOp == OP_COUNT_UP) || (cmdOp == OP_COUNT_DOWN) ||
                      (cmdOp == OP_SHIFT_LEFT);

    // Bit i toggles when all lower bits are 1 (up) or all are 0 (down).
    always_comb begin
        logic upAcc;
        logic downAcc;
        upAcc      = 1'b1;
        downAcc    = 1'b1;
        upToggle   = '0;
        downToggle = '0;
        for (int i = 0; i < WIDTH; i++) begin
            upToggle[i]   = upAcc;
            downToggle[i] = downAcc;
            upAcc         = upAcc & q_q[i];
            downAcc       = downAcc & ~q_q[i];
        end
    end

    assign shifted = {q_q[WIDTH-2:0], 1'b0};

    always_comb begin
        jDrive = '0;
        kDrive = '0;
        if (state_q == EXEC) begin
            case (op_q)
                OP_CLEAR: begin
                    jDrive = '0;
                    kDrive = '1;
                end
                OP_SET: begin
                    jDrive = '1;
                    kDrive = '0;
                end
                OP_COMPLEMENT: begin
                    jDrive = '1;
                    kDrive = '1;
                end
                OP_LOAD: begin
                    jDrive = data_q;
                    kDrive = ~data_q;
                end
                OP_COUNT_UP: begin
                    jDrive = upToggle;
                    kDrive = upToggle;
                end
                OP_COUNT_DOWN: begin
                    jDrive = downToggle;
                    kDrive = downToggle;
                end
                OP_SHIFT_LEFT: begin
                    jDrive = shifted;
                    kDrive = ~shifted;
                end
                default: begin
                    jDrive = '0;
                    kDrive = '0;
                end
            endcase
        end
    end

    assign q_d = (jDrive & ~q_q) | (~kDrive & q_q);

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    always_ff @(posedge clk or posedge reset_async) begin
        if (reset_async) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            data_q  <= '0;
            rem_q   <= '0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= cmdOp;
                        data_q  <= cmd_data;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b0;
                        if (cmdOp == OP_NOP || (isStepOp && cmd_len == '0)) begin
                            rem_q   <= cmd_len;
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            rem_q   <= isStepOp ? cmd_len : CNT_W'(1);
                            state_q <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    rem_q <= rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign J         = jDrive;
    assign K         = kDrive;
    assign Q         = q_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign cmd_ready = ready_q;

endmodule

// File: tb/tb_jk_register_controller.sv
// Directed bench for jk_register_controller: one task per scenario plus a
// free-running monitor that checks every Q update against the JK equation.
module tb_jk_register_controller;

    localparam logic [2:0] OP_NOP        = 3'b000;
    localparam logic [2:0] OP_SET        = 3'b010;
    localparam logic [2:0] OP_COMPLEMENT = 3'b011;
    localparam logic [2:0] OP_LOAD       = 3'b100;
    localparam logic [2:0] OP_COUNT_UP   = 3'b101;
    localparam logic [2:0] OP_COUNT_DOWN = 3'b110;
    localparam logic [2:0] OP_SHIFT_LEFT = 3'b111;

    logic       clk;
    logic       reset_async;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] cmd_len;
    logic [3:0] J;
    logic [3:0] K;
    logic [3:0] Q;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    logic       skipJk = 1'b0;
    logic       prevValid = 1'b0;
    logic [3:0] prevJ;
    logic [3:0] prevK;
    logic [3:0] prevQ;
    logic [3:0] jkExpect;

    jk_register_controller #(.WIDTH(4), .CNT_W(4)) dut (
        .clk        (clk),
        .reset_async(reset_async),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .cmd_len    (cmd_len),
        .J          (J),
        .K          (K),
        .Q          (Q),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each negedge, Q must equal the JK characteristic applied to the previous sample.
    always @(negedge clk) begin
        if (reset_async) begin
            prevValid = 1'b0;
        end else begin
            if (prevValid && !skipJk) begin
                jkExpect = (prevJ & ~prevQ) | (~prevK & prevQ);
                checks++;
                if (Q !== jkExpect) begin
                    errors++;
                    $display("[TB] FAIL jk_equation: Q=%b expected %b (J=%b K=%b Qprev=%b)",
                             Q, jkExpect, prevJ, prevK, prevQ);
                end
            end
            prevJ     = J;
            prevK     = K;
            prevQ     = Q;
            prevValid = 1'b1;
            skipJk    = 1'b0;
        end
    end

    task automatic startCmd(input logic [2:0] op, input logic [3:0] data, input logic [3:0] len);
        cmd_op    = op;
        cmd_data  = data;
        cmd_len   = len;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = ~data;
        cmd_len   = ~len;
    endtask

    task automatic loadValue(input logic [3:0] value);
        startCmd(OP_LOAD, value, 4'd0);
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic pulseReset();
        #1;
        reset_async = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        checks++;
        if (Q !== 4'b0000 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL por_state: Q=%b ready=%b busy=%b done=%b expected 0000/1/0/0",
                     Q, cmd_ready, busy, done);
        end
        reset_async = 1'b0;
        startCmd(OP_SET, 4'b0000, 4'd0);
        @(negedge clk);
        checks++;
        if (Q !== 4'b1111 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL set_before_reset: Q=%b done=%b expected 1111/1", Q, done);
        end
        pulseReset();
        checks++;
        if (Q !== 4'b0000 || cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: Q=%b ready=%b busy=%b done=%b expected 0000/1/0/0",
                     Q, cmd_ready, busy, done);
        end
        reset_async = 1'b0;
        skipJk      = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_complement();
        startCmd(OP_LOAD, 4'b1010, 4'd7);
        checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0 || J !== 4'b1010 || K !== 4'b0101 || Q !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL load_exec: busy=%b ready=%b J=%b K=%b Q=%b expected 1/0/1010/0101/0000",
                     busy, cmd_ready, J, K, Q);
        end
        @(negedge clk);
        checks++;
        if (Q !== 4'b1010 || done !== 1'b1 || J !== 4'b0000 || K !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL load_done: Q=%b done=%b J=%b K=%b expected 1010/1/0000/0000", Q, done, J, K);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL load_idle: done=%b ready=%b busy=%b expected 0/1/0", done, cmd_ready, busy);
        end
        startCmd(OP_COMPLEMENT, 4'b0000, 4'd0);
        checks++;
        if (J !== 4'b1111 || K !== 4'b1111) begin
            errors++;
            $display("[TB] FAIL complement_drive: J=%b K=%b expected 1111/1111", J, K);
        end
        @(negedge clk);
        checks++;
        if (Q !== 4'b0101 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL complement_done: Q=%b done=%b expected 0101/1", Q, done);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL complement_idle: done=%b ready=%b expected 0/1", done, cmd_ready);
        end
    endtask

    task automatic test_multistep(input string name, input logic [2:0] op, input logic [3:0] startVal,
                                  input logic [3:0] len, input logic [3:0] exp0, input logic [3:0] exp1,
                                  input logic [3:0] exp2, input logic [3:0] exp3, input logic [3:0] exp4);
        logic [3:0] expSeq [5];
        int busyCycles;
        expSeq = '{exp0, exp1, exp2, exp3, exp4};
        loadValue(startVal);
        startCmd(op, 4'b0000, len);
        busyCycles = 0;
        for (int k = 0; k < int'(len); k++) begin
            if (busy === 1'b1) busyCycles++;
            @(negedge clk);
            checks++;
            if (Q !== expSeq[k] || done !== (k == int'(len) - 1)) begin
                errors++;
                $display("[TB] FAIL %s_step%0d: Q=%b done=%b expected %b/%0b",
                         name, k, Q, done, expSeq[k], (k == int'(len) - 1));
            end
        end
        for (int c = 0; c < 20 && busy === 1'b1; c++) begin
            busyCycles++;
            @(negedge clk);
        end
        checks++;
        if (busyCycles != int'(len) + 1 || done !== 1'b0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_busy: busyCycles=%0d done=%b ready=%b expected %0d/0/1",
                     name, busyCycles, done, cmd_ready, int'(len) + 1);
        end
    endtask

    task automatic test_len_zero();
        startCmd(OP_COUNT_UP, 4'b0000, 4'd0);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || Q !== 4'b1100 || J !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL len_zero_done: done=%b busy=%b Q=%b J=%b expected 1/1/1100/0000",
                     done, busy, Q, J);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || Q !== 4'b1100 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL len_zero_idle: ready=%b Q=%b done=%b expected 1/1100/0", cmd_ready, Q, done);
        end
        startCmd(OP_NOP, 4'b1111, 4'd3);
        checks++;
        if (done !== 1'b1 || Q !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL nop_done: done=%b Q=%b expected 1/1100", done, Q);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [3:0] expSeq [4];
        expSeq = '{4'b1101, 4'b1110, 4'b1110, 4'b1110};
        cmd_op    = OP_COUNT_UP;
        cmd_len   = 4'd2;
        cmd_data  = 4'b0000;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_op   = OP_LOAD;
        cmd_data = 4'b0011;
        cmd_len  = 4'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (Q !== expSeq[k] || cmd_ready !== (k == 2)) begin
                errors++;
                $display("[TB] FAIL held_valid_cycle%0d: Q=%b ready=%b expected %b/%0b",
                         k, Q, cmd_ready, expSeq[k], (k == 2));
            end
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || J !== 4'b0011 || K !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL held_valid_accept: busy=%b J=%b K=%b expected 1/0011/1100", busy, J, K);
        end
        @(negedge clk);
        checks++;
        if (Q !== 4'b0011 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL held_valid_load: Q=%b done=%b expected 0011/1", Q, done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_count();
        int doneSeen;
        startCmd(OP_COUNT_UP, 4'b0000, 4'd8);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (Q !== 4'b0110 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_count_progress: Q=%b busy=%b expected 0110/1", Q, busy);
        end
        pulseReset();
        checks++;
        if (Q !== 4'b0000 || busy !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_count_reset: Q=%b busy=%b ready=%b done=%b expected 0000/0/1/0",
                     Q, busy, cmd_ready, done);
        end
        reset_async = 1'b0;
        skipJk      = 1'b1;
        doneSeen    = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done !== 1'b0 || Q !== 4'b0000) doneSeen++;
        end
        checks++;
        if (doneSeen != 0) begin
            errors++;
            $display("[TB] FAIL mid_count_abort: %0d bad cycles after reset, expected 0", doneSeen);
        end
    endtask

    initial begin
        reset_async = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = 3'b000;
        cmd_data    = 4'b0000;
        cmd_len     = 4'd0;
        repeat (2) @(negedge clk);
        test_reset();
        test_load_complement();
        test_multistep("count_up", OP_COUNT_UP, 4'b1101, 4'd5,
                       4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b0010);
        test_multistep("count_down", OP_COUNT_DOWN, 4'b0001, 4'd3,
                       4'b0000, 4'b1111, 4'b1110, 4'b0000, 4'b0000);
        test_multistep("shift_left", OP_SHIFT_LEFT, 4'b1011, 4'd2,
                       4'b0110, 4'b1100, 4'b0000, 4'b0000, 4'b0000);
        test_len_zero();
        test_back_to_back();
        test_reset_mid_count();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/jk_register_controller.md
Name: jk_register_controller

Overview:
- Command-driven sequencer for a WIDTH-bit register built from JK flip-flops; it generates the per-bit J/K drive each cycle.
- Accepts one command at a time over a valid/ready handshake.
- Executes clear, set, complement, load, multi-step count up/down and multi-step shift-left.
- Sits between a control source (bench or upper FSM) and the JK register bank. It exposes J, K and Q so the storage can be checked against the JK characteristic equation.

Parameters:
- WIDTH, 4, register width in bits (>=2).
- CNT_W, 4, width of the step-count argument cmd_len.

Ports:
- clk  input  1  rising-edge clock.
- reset_async  input  1  asynchronous reset, active-high.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command (high only in IDLE).
- cmd_op  input  3  000 NOP, 001 CLEAR, 010 SET, 011 COMPLEMENT, 100 LOAD, 101 COUNT_UP, 110 COUNT_DOWN, 111 SHIFT_LEFT.
- cmd_data  input  WIDTH  load value (LOAD only).
- cmd_len  input  CNT_W  number of steps (COUNT_UP/COUNT_DOWN/SHIFT_LEFT only).
- J  output  WIDTH  per-bit J drive into the register bank.
- K  output  WIDTH  per-bit K drive into the register bank.
- Q  output  WIDTH  register contents.
- busy  output  1  high whenever state != IDLE.
- done  output  1  one-cycle pulse in the DONE state.

Behaviour:
- Storage: every posedge clk, Q[i] <= (J[i] & ~Q[i]) | (~K[i] & Q[i]) for each bit. This is the only path that updates Q.
- Reset:
  - reset_async=1 forces state=IDLE, Q=0, latched op/data/remaining=0 and done=0 immediately, independent of clk.
  - Reset mid-command aborts the command with no DONE pulse.
  - First accept is possible at the first posedge after reset deasserts.
- States: IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1, J=K=0 (hold).
  - On a posedge with cmd_valid=1, latch cmd_op, cmd_data and cmd_len (remaining <= cmd_len).
  - NOP goes to DONE.
  - COUNT_UP, COUNT_DOWN or SHIFT_LEFT with cmd_len=0 goes to DONE (no change to Q).
  - Otherwise go to EXEC; CLEAR, SET, COMPLEMENT and LOAD force remaining <= 1.
- EXEC: J/K are combinational from the latched op and current Q.
  - CLEAR: J=0, K=all 1.
  - SET: J=all 1, K=0.
  - COMPLEMENT: J=K=all 1.
  - LOAD: J=data, K=~data.
  - COUNT_UP: J[i]=K[i]=AND of Q[i-1:0]; bit 0 always toggles.
  - COUNT_DOWN: J[i]=K[i]=NOR of Q[i-1:0]; bit 0 always toggles.
  - SHIFT_LEFT: n = {Q[WIDTH-2:0],1'b0}, J=n, K=~n.
  - Each EXEC posedge applies one step and decrements remaining. When remaining==1 at a posedge, go to DONE.
- DONE:
  - J=K=0, done=1, busy=1, cmd_ready=0.
  - Next posedge goes to IDLE.
- Latency: a command of n steps accepted at edge t updates Q at edges t+1..t+n. done is high during cycle t+n+1 (t+1 for NOP or len 0). The next command can be accepted at edge t+n+2.
- Wrap-around:
  - COUNT_UP from all-ones gives 0.
  - COUNT_DOWN from 0 gives all-ones.
  - SHIFT_LEFT discards the MSB.
- cmd_valid while cmd_ready=0 is ignored and not queued; the source must hold it.
- cmd_data and cmd_len changes after accept have no effect.

Test Plan:
- Reset: pulse reset_async with no clock edge -> Q=0000, cmd_ready=1, busy=0, done=0 immediately.
- LOAD then COMPLEMENT: LOAD 1010, then COMPLEMENT -> Q=1010 one edge after LOAD accept, J=1010/K=0101 during EXEC; Q=0101 after COMPLEMENT; done one cycle each.
- COUNT_UP from 1101 with len=5 -> Q steps 1110, 1111, 0000, 0001, 0010; done one cycle after the fifth step; busy for 6 cycles.
- COUNT_DOWN from 0001 with len=3 -> Q steps 0000, 1111, 1110.
- SHIFT_LEFT from 1011 with len=2 -> Q steps 0110, 1100.
- Boundaries:
  - COUNT_UP with len=0 -> DONE next cycle, Q unchanged.
  - cmd_valid held during busy -> not accepted until IDLE.
  - reset_async mid-COUNT_UP (len=8, after 3 steps) -> Q=0000, IDLE, no done pulse.
- Every cycle, check Q_next against J/K/Q with the JK characteristic equation.
